// File: rtl/panel_scan_ctrl.sv
// Row/PWM scan sequencer for a HUB75-style panel fed from an AL422 FIFO.
// Shifts one row, latches it, displays it, then rewinds the FIFO once per PWM subframe.
module panel_scan_ctrl #(
  parameter int COLS           = 64,
  parameter int ROWS           = 16,
  parameter int ROW_BITS       = 4,
  parameter int PWM_MAX        = 30,
  parameter int LAT_CYCLES     = 2,
  parameter int DISPLAY_CYCLES = 32,
  parameter int RRST_CYCLES    = 2
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_enable,
  input  logic                pixel_strobe,
  output logic                rd_en,
  output logic                fifo_rrst_n,
  output logic                lat,
  output logic                oe_n,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [7:0]          pwm_value,
  output logic                frame_done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REWIND  = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_DISPLAY = 3'd4;

  localparam int CNT_MAX0 = (LAT_CYCLES > RRST_CYCLES) ? LAT_CYCLES : RRST_CYCLES;
  localparam int CNT_MAX  = (DISPLAY_CYCLES > CNT_MAX0) ? DISPLAY_CYCLES : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int COL_W    = $clog2(COLS + 1);

  localparam logic [CNT_W-1:0]    RRST_LAST = CNT_W'(RRST_CYCLES - 1);
  localparam logic [CNT_W-1:0]    LAT_LAST  = CNT_W'(LAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    DISP_LAST = CNT_W'(DISPLAY_CYCLES - 1);
  localparam logic [COL_W-1:0]    COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(ROWS - 1);
  localparam logic [7:0]          PWM_LAST  = 8'(PWM_MAX);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
  logic [ROW_BITS-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
  logic [7:0]          pwm_q, pwm_d;
  logic                frame_done_q, frame_done_d;
  logic                rd_en_q, rrst_n_q, lat_q, oe_n_q;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q + 1'b1;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    row_addr_d   = row_addr_q;
    pwm_d        = pwm_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (in_enable) state_d = (row_cnt_q == '0) ? ST_REWIND : ST_SHIFT;
      end
      ST_REWIND: begin
        if (cyc_q == RRST_LAST) begin
          state_d = ST_SHIFT;
          cyc_d   = '0;
        end
      end
      ST_SHIFT: begin
        cyc_d = '0;
        if (pixel_strobe) begin
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d  = '0;
            row_addr_d = row_cnt_q;
            state_d    = ST_LATCH;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (cyc_q == LAT_LAST) begin
          state_d = ST_DISPLAY;
          cyc_d   = '0;
        end
      end
      ST_DISPLAY: begin
        if (cyc_q == DISP_LAST) begin
          cyc_d = '0;
          // Last row closes the subframe: advance PWM and rewind the frame store.
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d = '0;
            if (pwm_q == PWM_LAST) begin
              pwm_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              pwm_d = pwm_q + 1'b1;
            end
            state_d = in_enable ? ST_REWIND : ST_IDLE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
            state_d   = in_enable ? ST_SHIFT : ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      row_addr_q   <= '0;
      pwm_q        <= '0;
      frame_done_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rrst_n_q     <= 1'b1;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      row_addr_q   <= row_addr_d;
      pwm_q        <= pwm_d;
      frame_done_q <= frame_done_d;
      // Strobes decode the next state so they line up exactly with state_q.
      rd_en_q      <= (state_d == ST_SHIFT);
      rrst_n_q     <= (state_d != ST_REWIND);
      lat_q        <= (state_d == ST_LATCH);
      oe_n_q       <= (state_d != ST_DISPLAY);
    end
  end

  assign rd_en       = rd_en_q;
  assign fifo_rrst_n = rrst_n_q;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign row_addr    = row_addr_q;
  assign pwm_value   = pwm_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Directed-plus-random bench for panel_scan_ctrl with a row/subframe-level reference model.
module tb_panel_scan_ctrl;
  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int ROW_BITS = 1;
  localparam int PWM_MAX = 2;
  localparam int LAT = 2;
  localparam int DISP = 3;
  localparam int RRST = 2;

  logic in_clk, in_rst, in_enable, pixel_strobe;
  logic rd_en, fifo_rrst_n, lat, oe_n, frame_done;
  logic [ROW_BITS-1:0] row_addr;
  logic [7:0] pwm_value;

  int n_asserts = 0;
  int n_fail = 0;
  int m_row = 0;
  int m_pwm = 0;

  panel_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .ROW_BITS(ROW_BITS), .PWM_MAX(PWM_MAX),
    .LAT_CYCLES(LAT), .DISPLAY_CYCLES(DISP), .RRST_CYCLES(RRST)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable), .pixel_strobe(pixel_strobe),
    .rd_en(rd_en), .fifo_rrst_n(fifo_rrst_n), .lat(lat), .oe_n(oe_n),
    .row_addr(row_addr), .pwm_value(pwm_value), .frame_done(frame_done)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge in_clk) begin
    if (!in_rst) begin
      n_asserts++;
      assert (!(lat === 1'b1 && oe_n === 1'b0)) else begin
        n_fail++;
        $error("FAIL lat_oe_overlap: observed lat=%b oe_n=%b expected never both active", lat, oe_n);
      end
      n_asserts++;
      assert (!(rd_en === 1'b1 && fifo_rrst_n === 1'b0)) else begin
        n_fail++;
        $error("FAIL rd_rrst_overlap: observed rd_en=%b fifo_rrst_n=%b expected never both active", rd_en, fifo_rrst_n);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic rewind();
    int n = 0;
    while (fifo_rrst_n === 1'b0 && n < 20) begin
      check("rew_rd_en", 32'(rd_en), 32'd0);
      check("rew_pwm", 32'(pwm_value), 32'(m_pwm));
      check("rew_oe_n", 32'(oe_n), 32'd1);
      if (n > 0) check("rew_frame_done", 32'(frame_done), 32'd0);
      pixel_strobe = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    pixel_strobe = 1'b0;
    check("rew_cycles", 32'(n), 32'(RRST));
    check("rew_then_rd_en", 32'(rd_en), 32'd1);
    check("rew_then_pwm", 32'(pwm_value), 32'(m_pwm));
  endtask

  // Drives exactly COLS strobes with random gaps; ends on the first LATCH sample.
  task automatic shift_pixels(input bit drop_en);
    for (int k = 0; k < COLS; k++) begin
      int gap = $urandom_range(0, 2);
      pixel_strobe = 1'b0;
      repeat (gap) begin
        tick();
        check("shift_hold_rd_en", 32'(rd_en), 32'd1);
      end
      if (drop_en && k == 1) in_enable = 1'b0;
      pixel_strobe = 1'b1;
      tick();
      pixel_strobe = 1'b0;
      if (k < COLS - 1) begin
        check("shift_rd_en", 32'(rd_en), 32'd1);
      end else begin
        check("shift_end_rd_en", 32'(rd_en), 32'd0);
        check("latch_entry_lat", 32'(lat), 32'd1);
      end
    end
  endtask

  task automatic latch_display();
    int n = 0;
    while (lat === 1'b1 && n < 20) begin
      check("latch_oe_n", 32'(oe_n), 32'd1);
      check("latch_row_addr", 32'(row_addr), 32'(m_row));
      check("latch_rd_en", 32'(rd_en), 32'd0);
      pixel_strobe = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("lat_cycles", 32'(n), 32'(LAT));
    n = 0;
    while (oe_n === 1'b0 && n < 20) begin
      check("disp_lat", 32'(lat), 32'd0);
      check("disp_row_addr", 32'(row_addr), 32'(m_row));
      check("disp_rd_en", 32'(rd_en), 32'd0);
      pixel_strobe = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    pixel_strobe = 1'b0;
    check("disp_cycles", 32'(n), 32'(DISP));
  endtask

  task automatic run_row(input bit drop_en);
    bit last, wrap;
    check("row_start_rd_en", 32'(rd_en), 32'd1);
    check("row_start_pwm", 32'(pwm_value), 32'(m_pwm));
    shift_pixels(drop_en);
    latch_display();
    last = (m_row == ROWS - 1);
    wrap = last && (m_pwm == PWM_MAX);
    if (last) begin
      m_row = 0;
      m_pwm = wrap ? 0 : m_pwm + 1;
    end else begin
      m_row = m_row + 1;
    end
    check("row_end_frame_done", 32'(frame_done), 32'(wrap));
    check("row_end_pwm", 32'(pwm_value), 32'(m_pwm));
    check("row_end_oe_n", 32'(oe_n), 32'd1);
    check("row_end_lat", 32'(lat), 32'd0);
    if (!drop_en) begin
      if (last) begin
        rewind();
      end else begin
        check("next_row_rd_en", 32'(rd_en), 32'd1);
        check("next_row_rrst_n", 32'(fifo_rrst_n), 32'd1);
      end
    end else begin
      check("idle_rd_en", 32'(rd_en), 32'd0);
      check("idle_rrst_n", 32'(fifo_rrst_n), 32'd1);
      repeat (3) begin
        pixel_strobe = 1'($urandom_range(0, 1));
        tick();
        check("idle_hold_oe_n", 32'(oe_n), 32'd1);
        check("idle_hold_rd_en", 32'(rd_en), 32'd0);
        check("idle_hold_rrst_n", 32'(fifo_rrst_n), 32'd1);
        check("idle_hold_lat", 32'(lat), 32'd0);
        check("idle_hold_pwm", 32'(pwm_value), 32'(m_pwm));
        check("idle_hold_frame_done", 32'(frame_done), 32'd0);
      end
      pixel_strobe = 1'b0;
      in_enable = 1'b1;
      tick();
      if (m_row == 0) begin
        check("resume_rrst_n", 32'(fifo_rrst_n), 32'd0);
        rewind();
      end else begin
        check("resume_rd_en", 32'(rd_en), 32'd1);
        check("resume_rrst_n", 32'(fifo_rrst_n), 32'd1);
      end
    end
  endtask

  initial begin
    in_rst = 1'b1;
    in_enable = 1'b0;
    pixel_strobe = 1'b0;
    repeat (2) tick();
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rrst_n", 32'(fifo_rrst_n), 32'd1);
    check("rst_lat", 32'(lat), 32'd0);
    check("rst_oe_n", 32'(oe_n), 32'd1);
    check("rst_row_addr", 32'(row_addr), 32'd0);
    check("rst_pwm", 32'(pwm_value), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    in_rst = 1'b0;
    in_enable = 1'b1;
    tick();
    check("start_rrst_n", 32'(fifo_rrst_n), 32'd0);
    rewind();

    // Three full subframes: pwm 0,1,2 then wrap to 0.
    for (int r = 0; r < 3 * ROWS; r++) run_row(1'b0);
    check("wrap_pwm", 32'(pwm_value), 32'd0);

    // Enable dropped during the last row, then during the first row.
    run_row(1'b0);
    run_row(1'b1);
    check("drop_last_pwm", 32'(m_pwm), 32'd1);
    run_row(1'b1);
    run_row(1'b0);

    // Asynchronous reset mid-DISPLAY.
    shift_pixels(1'b0);
    while (lat === 1'b1) begin
      pixel_strobe = 1'b0;
      tick();
    end
    check("pre_rst_oe_n", 32'(oe_n), 32'd0);
    #2;
    in_rst = 1'b1;
    #1;
    check("arst_oe_n", 32'(oe_n), 32'd1);
    check("arst_lat", 32'(lat), 32'd0);
    check("arst_rd_en", 32'(rd_en), 32'd0);
    check("arst_row_addr", 32'(row_addr), 32'd0);
    check("arst_pwm", 32'(pwm_value), 32'd0);
    check("arst_rrst_n", 32'(fifo_rrst_n), 32'd1);
    m_row = 0;
    m_pwm = 0;
    tick();
    in_rst = 1'b0;
    tick();
    check("post_rst_rrst_n", 32'(fifo_rrst_n), 32'd0);
    rewind();
    run_row(1'b0);
    run_row(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/panel_scan_ctrl.md
Name: panel_scan_ctrl

Overview:
- Sequencer directly downstream of the 2-byte RGB receive stage.
- Counts pixel strobes from that stage and gates its FIFO reads.
- Drives the panel latch, output enable and row address, and generates the pwm_value the receive stage compares colours against.
- Rewinds the AL422 read pointer at the end of each PWM subframe, so one stored frame is re-scanned once per PWM level.

Parameters:
- COLS, 64, pixel strobes per row.
- ROWS, 16, scanned rows per subframe.
- ROW_BITS, 4, width of row_addr (2^ROW_BITS >= ROWS).
- PWM_MAX, 30, last pwm_value before wrap to 0 (31 subframes for 5-bit colour).
- LAT_CYCLES, 2, lat high duration in clocks (>=1).
- DISPLAY_CYCLES, 32, oe_n low duration per row in clocks (>=1).
- RRST_CYCLES, 2, fifo_rrst_n low duration in clocks (>=1).

Ports:
- in_clk  input  1  system clock, all logic on rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_enable  input  1  run request, level.
- pixel_strobe  input  1  one-cycle pulse per pixel column shifted into the panel.
- rd_en  output  1  enables the FIFO read / receive stage while a row is shifting.
- fifo_rrst_n  output  1  AL422 read-pointer reset, active low.
- lat  output  1  panel latch.
- oe_n  output  1  panel output enable, active low.
- row_addr  output  ROW_BITS  displayed row address.
- pwm_value  output  8  compare level for the receive stage; bits above the PWM counter width are 0.
- frame_done  output  1  one-cycle pulse when pwm_value wraps PWM_MAX->0.

Behaviour:
- Reset: in_rst high forces the following immediately, asynchronously, including mid-operation:
  - state IDLE.
  - Outputs: rd_en=0, fifo_rrst_n=1, lat=0, oe_n=1, row_addr=0, pwm_value=0, frame_done=0.
  - Internals: col_cnt=0, row_cnt=0.
- All outputs are registered.
- States: IDLE, REWIND, SHIFT, LATCH, DISPLAY.
- IDLE:
  - All strobes are inactive; oe_n=1.
  - If in_enable=1: go to REWIND when row_cnt==0, else to SHIFT.
- REWIND:
  - fifo_rrst_n=0 for exactly RRST_CYCLES clocks, then go to SHIFT.
  - pwm_value advances only when REWIND is entered from DISPLAY (end of subframe), never when entered from IDLE.
- SHIFT:
  - rd_en=1 from the first SHIFT cycle.
  - Each sampled pixel_strobe increments col_cnt.
  - On the clock that samples the COLS-th strobe: col_cnt clears, next state is LATCH, and rd_en is 0 from the next cycle.
- pixel_strobe outside SHIFT is ignored. So are strobes arriving after the COLS-th one.
- LATCH:
  - On entry, row_addr <= row_cnt; this is the only place row_addr changes, always with oe_n=1.
  - lat=1 for LAT_CYCLES clocks, then go to DISPLAY.
- DISPLAY:
  - oe_n=0 for DISPLAY_CYCLES clocks.
  - On exit, oe_n=1 and the row advances:
    - row_cnt<ROWS-1: row_cnt++, next state SHIFT (IDLE if in_enable=0).
    - row_cnt==ROWS-1: row_cnt=0, pwm_value++ (wraps PWM_MAX->0), next state REWIND (IDLE if in_enable=0; the rewind then happens on the IDLE exit).
- frame_done is a 1-clock pulse on the clock pwm_value becomes 0 by wrap.
- in_enable is sampled only in IDLE and at DISPLAY exit.
  - Deassertion mid-row completes the row through DISPLAY, then goes to IDLE.
  - row_cnt and pwm_value are retained; resume continues at the retained row.
- lat and oe_n low are never asserted in the same cycle.
- rd_en is never high outside SHIFT.
- fifo_rrst_n is never low outside REWIND.

Test Plan:
All scenarios use COLS=4, ROWS=2, LAT_CYCLES=2, DISPLAY_CYCLES=3, RRST_CYCLES=2, PWM_MAX=2.
1. Release reset, in_enable=1 -> fifo_rrst_n low exactly 2 clocks, then rd_en=1; pwm_value stays 0 throughout.
2. Four pixel_strobe pulses 2 clocks apart in SHIFT -> rd_en drops the clock after the 4th pulse. Then lat high 2 clocks with row_addr=0 and oe_n=1, then oe_n low 3 clocks.
3. Complete rows 0 and 1 -> row_addr goes 0 then 1; after row 1 DISPLAY, pwm_value=1 and fifo_rrst_n low 2 clocks. Run 3 subframes -> pwm_value sequence 0,1,2,0 with a single frame_done pulse at the wrap.
4. Extra pixel_strobe pulses during LATCH/DISPLAY, and a 5th pulse in SHIFT -> col_cnt unaffected by them; exactly 4 strobes counted per row.
5. Drop in_enable during SHIFT of row 1 -> row completes through DISPLAY, then IDLE with row_cnt=0, pwm_value=1 and oe_n=1. Re-assert -> REWIND with no pwm advance, then SHIFT.
6. Assert in_rst during DISPLAY -> same clock: oe_n=1, lat=0, rd_en=0, row_addr=0, pwm_value=0, state IDLE.
